// File: rtl/amo_rmw_if.sv
// AMO request/response and memory-port bundle for amo_rmw.
// The slave side is the AMO unit; the master side is the requester plus memory.
interface amo_rmw_if #(parameter int XLEN = 64);
  logic              AMOStart;
  logic [6:0]        AMOFunct7;
  logic [2:0]        AMOFunct3;
  logic [XLEN-1:0]   AMOAdr;
  logic [XLEN-1:0]   AMOWData;
  logic              AMOBusy;
  logic              AMODone;
  logic              AMOFault;
  logic [XLEN-1:0]   AMOReadData;
  logic              MemReq;
  logic              MemWrite;
  logic [XLEN-1:0]   MemAdr;
  logic [XLEN/8-1:0] MemByteEn;
  logic [XLEN-1:0]   MemWData;
  logic              MemAck;
  logic [XLEN-1:0]   MemRData;

  modport slave (
    input  AMOStart, AMOFunct7, AMOFunct3, AMOAdr, AMOWData, MemAck, MemRData,
    output AMOBusy, AMODone, AMOFault, AMOReadData,
           MemReq, MemWrite, MemAdr, MemByteEn, MemWData
  );

  modport master (
    output AMOStart, AMOFunct7, AMOFunct3, AMOAdr, AMOWData, MemAck, MemRData,
    input  AMOBusy, AMODone, AMOFault, AMOReadData,
           MemReq, MemWrite, MemAdr, MemByteEn, MemWData
  );
endinterface

// File: rtl/amo_rmw.sv
// Atomic read-modify-write engine: one aligned read, ALU op at access width,
// one lane-masked write back, then a single-cycle done pulse.
module amo_rmw #(
  parameter int XLEN  = 64,
  parameter bit ZABHA = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  amo_rmw_if.slave   io_bus
);
  localparam int BW   = XLEN / 8;
  localparam int OFFW = $clog2(BW);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      r_state;
  logic [4:0]      r_f5;
  logic [1:0]      r_sz;
  logic [XLEN-1:0] r_adr;
  logic [XLEN-1:0] r_wdata;
  logic            r_fault;
  logic [XLEN-1:0] r_rdata;
  logic [XLEN-1:0] r_wd;
  logic [BW-1:0]   r_be;

  logic [4:0]      w_f5_in;
  logic            w_bad_op;
  logic            w_bad_width;
  logic            w_misalign;
  logic            w_fault;
  logic [OFFW+2:0] w_shamt;
  logic [XLEN-1:0] w_lane;
  logic [XLEN-1:0] w_a_s, w_a_u, w_b_s, w_b_u;
  logic            w_lt_s, w_lt_u;
  logic [XLEN-1:0] w_res;
  logic [BW-1:0]   w_be_base;
  logic            w_unused;

  // Extend the low (8<<sz) bits of v to XLEN, signed or unsigned.
  function automatic logic [XLEN-1:0] ext(input logic [XLEN-1:0] v,
                                           input logic [1:0] sz, input logic sgn);
    logic [7:0]             sh;
    logic signed [XLEN-1:0] t;
    case (sz)
      2'b00:   sh = 8'(XLEN - 8);
      2'b01:   sh = 8'(XLEN - 16);
      2'b10:   sh = 8'(XLEN - 32);
      default: sh = 8'd0;
    endcase
    t = v << sh;
    if (sgn) ext = t >>> sh;
    else     ext = (v << sh) >> sh;
  endfunction

  assign w_unused = ^io_bus.AMOFunct7[1:0];

  always_comb begin
    w_f5_in = io_bus.AMOFunct7[6:2];
    case (w_f5_in)
      5'b00001, 5'b00000, 5'b00100, 5'b01100, 5'b01000,
      5'b10000, 5'b10100, 5'b11000, 5'b11100: w_bad_op = 1'b0;
      default:                                w_bad_op = 1'b1;
    endcase
    w_bad_width = io_bus.AMOFunct3[2]
                | ((io_bus.AMOFunct3[1:0] == 2'b11) && (XLEN == 32))
                | (!io_bus.AMOFunct3[1] && !ZABHA);
    case (io_bus.AMOFunct3[1:0])
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = io_bus.AMOAdr[0];
      2'b10:   w_misalign = |io_bus.AMOAdr[1:0];
      default: w_misalign = |io_bus.AMOAdr[2:0];
    endcase
    w_fault = w_bad_op | w_bad_width | w_misalign;
  end

  // Operand lane selection and ALU; only feeds registers, never MemWData directly.
  always_comb begin
    w_shamt = {r_adr[OFFW-1:0], 3'b000};
    w_lane  = io_bus.MemRData >> w_shamt;
    w_a_s   = ext(w_lane, r_sz, 1'b1);
    w_a_u   = ext(w_lane, r_sz, 1'b0);
    w_b_s   = ext(r_wdata, r_sz, 1'b1);
    w_b_u   = ext(r_wdata, r_sz, 1'b0);
    w_lt_s  = $signed(w_a_s) < $signed(w_b_s);
    w_lt_u  = w_a_u < w_b_u;
    case (r_f5)
      5'b00000: w_res = w_a_u + w_b_u;
      5'b00100: w_res = w_a_u ^ w_b_u;
      5'b01100: w_res = w_a_u & w_b_u;
      5'b01000: w_res = w_a_u | w_b_u;
      5'b10000: w_res = w_lt_s ? w_a_u : w_b_u;
      5'b10100: w_res = w_lt_s ? w_b_u : w_a_u;
      5'b11000: w_res = w_lt_u ? w_a_u : w_b_u;
      5'b11100: w_res = w_lt_u ? w_b_u : w_a_u;
      default:  w_res = w_b_u;
    endcase
    case (r_sz)
      2'b00:   w_be_base = BW'(1);
      2'b01:   w_be_base = BW'(3);
      2'b10:   w_be_base = BW'(15);
      default: w_be_base = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_f5    <= '0;
      r_sz    <= '0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_fault <= 1'b0;
      r_rdata <= '0;
      r_wd    <= '0;
      r_be    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (io_bus.AMOStart) begin
          r_f5    <= w_f5_in;
          r_sz    <= io_bus.AMOFunct3[1:0];
          r_adr   <= io_bus.AMOAdr;
          r_wdata <= io_bus.AMOWData;
          r_fault <= w_fault;
          if (w_fault) begin
            r_rdata <= '0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_READ;
          end
        end
        S_READ: if (io_bus.MemAck) begin
          r_rdata <= w_a_s;
          r_wd    <= ext(w_res, r_sz, 1'b0) << w_shamt;
          r_be    <= w_be_base << r_adr[OFFW-1:0];
          r_state <= S_WRITE;
        end
        S_WRITE: if (io_bus.MemAck) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.AMOBusy     = (r_state != S_IDLE);
  assign io_bus.AMODone     = (r_state == S_DONE);
  assign io_bus.AMOFault    = (r_state == S_DONE) && r_fault;
  assign io_bus.AMOReadData = r_rdata;
  assign io_bus.MemReq      = (r_state == S_READ) || (r_state == S_WRITE);
  assign io_bus.MemWrite    = (r_state == S_WRITE);
  assign io_bus.MemAdr      = {r_adr[XLEN-1:OFFW], {OFFW{1'b0}}};
  assign io_bus.MemByteEn   = (r_state == S_WRITE) ? r_be : '0;
  assign io_bus.MemWData    = r_wd;
endmodule

// File: tb/tb_amo_rmw.sv
// Directed bench for amo_rmw: vector table on a ZABHA=1 instance, plus
// hand sequences for reset abort, start-while-busy and ZABHA=0 faults.
module tb_amo_rmw;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  amo_rmw_if #(.XLEN(64)) b0 ();
  amo_rmw_if #(.XLEN(64)) b1 ();

  amo_rmw #(.XLEN(64), .ZABHA(1'b1)) u_dut0 (.clk(clk), .reset(reset), .io_bus(b0));
  amo_rmw #(.XLEN(64), .ZABHA(1'b0)) u_dut1 (.clk(clk), .reset(reset), .io_bus(b1));

  typedef struct {
    logic [4:0]  f5;
    logic [2:0]  f3;
    logic [63:0] adr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        fault;
    logic [63:0] rd;
    logic [63:0] wd;
    logic [7:0]  be;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int          done_cyc;
    logic        saw_req;
    logic        got_fault;
    logic [63:0] got_rd, got_wd, got_adr;
    logic [7:0]  got_be;
    done_cyc = -1; saw_req = 0; got_fault = 0;
    got_rd = '0; got_wd = '0; got_adr = '0; got_be = '0;
    @(negedge clk);
    b0.AMOStart  = 1'b1;
    b0.AMOFunct7 = {v.f5, 2'b11};
    b0.AMOFunct3 = v.f3;
    b0.AMOAdr    = v.adr;
    b0.AMOWData  = v.wdata;
    @(posedge clk); #1;
    b0.AMOStart = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      b0.MemAck = 1'b0;
      if (b0.MemReq) begin
        saw_req   = 1'b1;
        got_adr   = b0.MemAdr;
        b0.MemAck = 1'b1;
        if (b0.MemWrite) begin
          got_wd = b0.MemWData;
          got_be = b0.MemByteEn;
        end else begin
          b0.MemRData = v.rdata;
        end
      end
      if (b0.AMODone) begin
        done_cyc  = c;
        got_fault = b0.AMOFault;
        got_rd    = b0.AMOReadData;
        break;
      end
    end
    chk($sformatf("v%0d done_cycle", id), 64'(done_cyc), v.fault ? 64'd1 : 64'd3);
    chk($sformatf("v%0d fault", id), 64'(got_fault), 64'(v.fault));
    chk($sformatf("v%0d readdata", id), got_rd, v.rd);
    chk($sformatf("v%0d memreq_seen", id), 64'(saw_req), 64'(!v.fault));
    if (!v.fault) begin
      chk($sformatf("v%0d memadr", id), got_adr, v.adr & ~64'h7);
      chk($sformatf("v%0d wdata", id), got_wd, v.wd);
      chk($sformatf("v%0d byteen", id), 64'(got_be), 64'(v.be));
    end
    @(negedge clk);
    chk($sformatf("v%0d done_pulse_end", id), 64'(b0.AMODone), 64'd0);
    chk($sformatf("v%0d idle_after", id), 64'(b0.AMOBusy), 64'd0);
  endtask

  initial begin
    int          n_done;
    logic [63:0] wd_seen;

    vt[0]  = '{5'b00000, 3'b010, 64'h1004, 64'h1, 64'h7FFFFFFF_12345678,
               1'b0, 64'h00000000_7FFFFFFF, 64'h80000000_00000000, 8'hF0};
    vt[1]  = '{5'b10000, 3'b000, 64'h2003, 64'h7F, 64'h00000000_80000000,
               1'b0, 64'hFFFFFFFF_FFFFFF80, 64'h00000000_80000000, 8'h08};
    vt[2]  = '{5'b11100, 3'b011, 64'h3000, 64'h1, 64'hFFFFFFFF_FFFFFFFF,
               1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 8'hFF};
    vt[3]  = '{5'b10100, 3'b011, 64'h3008, 64'h1, 64'hFFFFFFFF_FFFFFFFF,
               1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h1, 8'hFF};
    vt[4]  = '{5'b00001, 3'b010, 64'h1002, 64'h5, 64'h0,
               1'b1, 64'h0, 64'h0, 8'h00};
    vt[5]  = '{5'b00001, 3'b001, 64'h4006, 64'hAAAA5555, 64'h12345678_9ABCDEF0,
               1'b0, 64'h1234, 64'h55550000_00000000, 8'hC0};
    vt[6]  = '{5'b00100, 3'b010, 64'h10, 64'hFFFFFFFF_0F0F00FF, 64'h00000000_F0F0F0F0,
               1'b0, 64'hFFFFFFFF_F0F0F0F0, 64'h00000000_FFFFF00F, 8'h0F};
    vt[7]  = '{5'b01100, 3'b011, 64'h18, 64'h0FF00FF0_0FF00FF0, 64'hFF00FF00_FF00FF00,
               1'b0, 64'hFF00FF00_FF00FF00, 64'h0F000F00_0F000F00, 8'hFF};
    vt[8]  = '{5'b01000, 3'b000, 64'h21, 64'h02, 64'h00000000_00004100,
               1'b0, 64'h41, 64'h4300, 8'h02};
    vt[9]  = '{5'b11000, 3'b001, 64'h2, 64'h7FFF, 64'h00000000_80000000,
               1'b0, 64'hFFFFFFFF_FFFF8000, 64'h7FFF0000, 8'h0C};
    vt[10] = '{5'b00010, 3'b010, 64'h0, 64'h1, 64'h0,
               1'b1, 64'h0, 64'h0, 8'h00};
    vt[11] = '{5'b00000, 3'b100, 64'h0, 64'h1, 64'h0,
               1'b1, 64'h0, 64'h0, 8'h00};
    vt[12] = '{5'b00000, 3'b011, 64'h4, 64'h1, 64'h0,
               1'b1, 64'h0, 64'h0, 8'h00};
    vt[13] = '{5'b00000, 3'b000, 64'h7, 64'h1, 64'hFF000000_00000000,
               1'b0, 64'hFFFFFFFF_FFFFFFFF, 64'h0, 8'h80};

    b0.AMOStart = 0; b0.AMOFunct7 = 0; b0.AMOFunct3 = 0; b0.AMOAdr = 0;
    b0.AMOWData = 0; b0.MemAck = 0; b0.MemRData = 0;
    b1.AMOStart = 0; b1.AMOFunct7 = 0; b1.AMOFunct3 = 0; b1.AMOAdr = 0;
    b1.AMOWData = 0; b1.MemAck = 0; b1.MemRData = 0;

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    b0.AMOStart = 1'b1;
    repeat (3) @(posedge clk);
    #1; reset = 1'b0; b0.AMOStart = 1'b0;
    @(negedge clk);
    chk("rst busy", 64'(b0.AMOBusy), 64'd0);
    chk("rst done", 64'(b0.AMODone), 64'd0);
    chk("rst fault", 64'(b0.AMOFault), 64'd0);
    chk("rst memreq", 64'(b0.MemReq), 64'd0);
    chk("rst memwrite", 64'(b0.MemWrite), 64'd0);
    chk("rst readdata", b0.AMOReadData, 64'd0);
    chk("rst memwdata", b0.MemWData, 64'd0);
    chk("rst byteen", 64'(b0.MemByteEn), 64'd0);

    for (int i = 0; i < 14; i++) run_vec(i, vt[i]);

    // Reset while WRITE is waiting for an ack abandons the operation.
    @(negedge clk);
    b0.AMOStart = 1'b1; b0.AMOFunct7 = 7'b0000000; b0.AMOFunct3 = 3'b010;
    b0.AMOAdr = 64'h1004; b0.AMOWData = 64'h1;
    @(posedge clk); #1; b0.AMOStart = 1'b0;
    @(negedge clk);
    b0.MemAck = 1'b1; b0.MemRData = 64'h7FFFFFFF_12345678;
    @(negedge clk);
    b0.MemAck = 1'b0;
    chk("abort in_write", 64'(b0.MemWrite), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("abort busy", 64'(b0.AMOBusy), 64'd0);
    chk("abort memreq", 64'(b0.MemReq), 64'd0);
    n_done = 0;
    for (int c = 0; c < 4; c++) begin
      if (b0.AMODone) n_done++;
      @(negedge clk);
    end
    chk("abort no_done", 64'(n_done), 64'd0);

    // Second start during READ must be ignored.
    b0.AMOStart = 1'b1; b0.AMOFunct7 = 7'b0000000; b0.AMOFunct3 = 3'b010;
    b0.AMOAdr = 64'h1004; b0.AMOWData = 64'h1;
    @(posedge clk); #1; b0.AMOStart = 1'b0;
    @(negedge clk);
    b0.AMOStart = 1'b1; b0.AMOFunct7 = 7'b0000100; b0.AMOFunct3 = 3'b011;
    b0.AMOAdr = 64'h2000; b0.AMOWData = 64'h55;
    @(posedge clk); #1; b0.AMOStart = 1'b0;
    @(negedge clk);
    chk("busy_start memadr", b0.MemAdr, 64'h1000);
    chk("busy_start still_read", 64'({b0.MemReq, b0.MemWrite}), 64'b10);
    n_done = 0; wd_seen = '0;
    for (int c = 0; c < 10; c++) begin
      b0.MemAck = b0.MemReq;
      b0.MemRData = 64'h7FFFFFFF_12345678;
      if (b0.MemReq && b0.MemWrite) wd_seen = b0.MemWData;
      if (b0.AMODone) n_done++;
      @(negedge clk);
    end
    b0.MemAck = 1'b0;
    chk("busy_start done_count", 64'(n_done), 64'd1);
    chk("busy_start wdata", wd_seen, 64'h80000000_00000000);
    chk("busy_start readdata", b0.AMOReadData, 64'h7FFFFFFF);

    // Sub-word AMO on the ZABHA=0 instance faults without touching memory.
    b1.AMOStart = 1'b1; b1.AMOFunct7 = 7'b0000000; b1.AMOFunct3 = 3'b001;
    b1.AMOAdr = 64'h10; b1.AMOWData = 64'h1;
    @(posedge clk); #1; b1.AMOStart = 1'b0;
    @(negedge clk);
    chk("z0 memreq", 64'(b1.MemReq), 64'd0);
    chk("z0 done", 64'(b1.AMODone), 64'd1);
    chk("z0 fault", 64'(b1.AMOFault), 64'd1);
    chk("z0 readdata", b1.AMOReadData, 64'd0);
    @(negedge clk);
    chk("z0 idle", 64'(b1.AMOBusy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/amo_rmw.md
AMO_RMW -- requirements
Module: amo_rmw

Interface
REQ-001 SHALL take parameter XLEN, default 64, legal 32|64: datapath and address width.
REQ-002 SHALL take parameter ZABHA, default 1: 1 = byte/halfword AMOs legal, 0 = they fault.
REQ-003 clk  in  1  sole clock, all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 AMOStart  in  1  request valid; accepted only in IDLE.
REQ-006 AMOFunct7  in  7  [6:2] = funct5 opcode; [1:0] aq/rl ignored.
REQ-007 AMOFunct3  in  3  width: 000 B, 001 H, 010 W, 011 D.
REQ-008 AMOAdr  in  XLEN  byte address.
REQ-009 AMOWData  in  XLEN  rs2 operand, low-aligned.
REQ-010 AMOBusy  out  1  high in every state except IDLE.
REQ-011 AMODone  out  1  one-cycle completion pulse.
REQ-012 AMOFault  out  1  valid with AMODone; 1 = illegal request, no memory access.
REQ-013 AMOReadData  out  XLEN  old memory value, sign-extended from access width.
REQ-014 MemReq  out  1  memory request valid.
REQ-015 MemWrite  out  1  1 = write, 0 = read; meaningful when MemReq=1.
REQ-016 MemAdr  out  XLEN  AMOAdr with low log2(XLEN/8) bits cleared.
REQ-017 MemByteEn  out  XLEN/8  lane enables for write.
REQ-018 MemWData  out  XLEN  new value placed at its byte lane, other lanes 0.
REQ-019 MemAck  in  1  completes current memory request.
REQ-020 MemRData  in  XLEN  read data, valid with MemAck in READ.

Function
REQ-021 FSM states SHALL be IDLE, READ, WRITE, DONE.
REQ-022 IDLE: AMOStart=1 SHALL latch Funct7/Funct3/Adr/WData and go to READ, or to DONE if faulting.
REQ-023 Fault SHALL be raised for: unlisted funct5; width 011 with XLEN=32; width 000/001 with ZABHA=0; width 1xx; address not aligned to access size.
REQ-024 READ: MemReq=1, MemWrite=0, MemByteEn=0; held until MemAck; on MemAck capture MemRData and go to WRITE.
REQ-025 Operand a SHALL be the MemRData lane at offset Adr[log2(XLEN/8)-1:0], truncated to access width; b = WData truncated to access width.
REQ-026 Ops (funct5): 00001 swap b; 00000 add a+b mod 2^w; 00100 xor; 01100 and; 01000 or; 10000 min; 10100 max (signed); 11000 minu; 11100 maxu (unsigned); comparisons at access width w.
REQ-027 Result SHALL be registered on the READ->WRITE edge; no combinational path from MemRData to MemWData.
REQ-028 WRITE: MemReq=1, MemWrite=1, MemByteEn = 2^(w/8)-1 shifted by lane offset; held stable until MemAck, then go to DONE.
REQ-029 DONE: AMODone=1 for exactly one cycle, then IDLE unconditionally.
REQ-030 AMOReadData SHALL update at the READ MemAck edge and hold until next accepted request; on fault it SHALL be 0.
REQ-031 AMOStart outside IDLE SHALL be ignored (no latch, no state change).
REQ-032 MemAck outside READ/WRITE SHALL be ignored.
REQ-033 Minimum latency (ack same cycle as request): start cycle 0, READ 1, WRITE 2, AMODone in cycle 3; fault: AMODone in cycle 1.
REQ-034 MemReq SHALL never be high in IDLE or DONE.

Reset
REQ-035 reset=1 SHALL force IDLE on the next edge from any state, abandoning any outstanding request.
REQ-036 After reset: AMOBusy, AMODone, AMOFault, MemReq, MemWrite = 0; AMOReadData, MemWData, MemByteEn = 0.
REQ-037 reset SHALL take priority over AMOStart and MemAck in the same cycle.

Verification (XLEN=64, ZABHA=1)
REQ-038 amoadd.w, Adr 0x1004, MemRData 0x7FFFFFFF_12345678, WData 1 -> MemAdr 0x1000, AMOReadData 0x00000000_7FFFFFFF, MemWData 0x80000000_00000000, MemByteEn 0xF0.
REQ-039 amomin.b, Adr 0x2003, byte lane 3 = 0x80, WData 0x7F -> MemWData 0x00000000_80000000, MemByteEn 0x08, AMOReadData 0xFFFFFFFF_FFFFFF80.
REQ-040 amomaxu.d, MemRData all-ones, WData 1 -> MemWData all-ones, MemByteEn 0xFF; same with amomax.d -> MemWData 1.
REQ-041 amoswap.w at Adr 0x1002 -> no MemReq, AMODone+AMOFault in cycle 1, AMOReadData 0; repeat with ZABHA=0 amoadd.h -> same fault.
REQ-042 reset asserted in WRITE with MemAck held 0 -> next cycle IDLE, MemReq 0, AMOBusy 0, no AMODone.
REQ-043 AMOStart pulsed during READ with different Adr -> ignored; only the first request completes, single AMODone.
